// File: rtl/mp3_pkg.sv
// mp3_pkg: shared types and defaults for the playback sample scheduler.
//   sched_state_t : scheduler FSM state encoding
//   DEF_ADDR_W    : default bridge word-address width
//   DEF_DATA_W    : default PCM sample width
//   SILENCE       : sample value substituted on underrun
package mp3_pkg;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_DATA_W = 16;

  localparam logic [15:0] SILENCE = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_SPACE,
    S_DRAIN,
    S_ABORT
  } sched_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample FIFO with push/pop/flush.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   push, push_data   : write one word (ignored when full, unless a pop frees a slot)
//   pop               : drop the head word (ignored when empty)
//   flush             : empty the FIFO; overrides push and pop
//   count             : number of stored words, 0..DEPTH
//   head              : oldest stored word, read from the storage flops
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_W-1:0]      head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a word is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sample_fetch_sched.sv
// sample_fetch_sched: playback scheduler between the SDRAM Avalon bridge and
// the I2S serializer. Streams PCM words from [start_addr..end_addr] into a
// small FIFO with hysteresis refill and hands one sample out per sample_req.
// Build option: LOOP_PLAYBACK_EN -- when defined, the clip repeats from
// start_addr after end_addr and playback ends only on stop.
// Ports:
//   Clk, Reset_n               : clock, synchronous active-low reset
//   start, stop                : 1-cycle control pulses
//   start_addr, end_addr       : inclusive word range, sampled on accepted start
//   bridge_address/read/byte_enable, bridge_acknowledge, bridge_read_data
//                              : Avalon read master, one outstanding read
//   sample_req                 : per-frame request from the serializer
//   sample_data, sample_valid  : sample answer, one cycle after sample_req
//   playing, underrun, done    : status (underrun sticky, done 1-cycle pulse)
//
// state        | meaning
// S_IDLE       | no clip active, waiting for start
// S_FETCH      | read outstanding on the bridge
// S_WAIT_SPACE | FIFO filled up, waiting for count <= LOW_WATER
// S_DRAIN      | whole clip fetched, waiting for FIFO to empty
// S_ABORT      | stopped with a read in flight, waiting for its ack
module sample_fetch_sched
  import mp3_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] bridge_address,
  output logic              bridge_read,
  output logic [1:0]        bridge_byte_enable,
  input  logic              bridge_acknowledge,
  input  logic [DATA_W-1:0] bridge_read_data,
  input  logic              sample_req,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              playing,
  output logic              underrun,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_r;
`ifdef LOOP_PLAYBACK_EN
  logic [ADDR_W-1:0] start_r;
`endif
  logic              load_range;
  logic              done_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              full_after;
  logic              start_ok;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (fifo_push),
    .push_data (bridge_read_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign fifo_pop   = sample_req && (fifo_count != '0);
  // A push fills the FIFO only if no pop lands in the same cycle.
  assign full_after = (fifo_count == CNT_W'(FIFO_DEPTH - 1)) && !fifo_pop;
  assign start_ok   = (state_q == S_IDLE) && start && !stop && (start_addr <= end_addr);

  assign bridge_address     = addr_q;
  assign bridge_read        = (state_q == S_FETCH) || (state_q == S_ABORT);
  assign bridge_byte_enable = 2'b11;
  assign playing            = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    load_range = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (start_addr <= end_addr) begin
            state_d    = S_FETCH;
            addr_d     = start_addr;
            load_range = 1'b1;
            fifo_flush = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (stop) begin
          // An ack in the stop cycle completes the read; its data is dropped.
          if (bridge_acknowledge) begin
            state_d    = S_IDLE;
            fifo_flush = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = S_ABORT;
          end
        end else if (bridge_acknowledge) begin
          fifo_push = 1'b1;
          if (addr_q == end_r) begin
`ifdef LOOP_PLAYBACK_EN
            addr_d = start_r;
            if (full_after) state_d = S_WAIT_SPACE;
`else
            state_d = S_DRAIN;
`endif
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (full_after) state_d = S_WAIT_SPACE;
          end
        end
      end
      S_WAIT_SPACE: begin
        if (stop) begin
          state_d    = S_IDLE;
          fifo_flush = 1'b1;
          done_d     = 1'b1;
        end else if (fifo_count <= CNT_W'(LOW_WATER)) begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (stop || (fifo_count == '0)) begin
          state_d    = S_IDLE;
          fifo_flush = 1'b1;
          done_d     = 1'b1;
        end
      end
      S_ABORT: begin
        if (bridge_acknowledge) begin
          state_d    = S_IDLE;
          fifo_flush = 1'b1;
          done_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      end_r   <= '0;
`ifdef LOOP_PLAYBACK_EN
      start_r <= '0;
`endif
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done    <= done_d;
      if (load_range) begin
        end_r   <= end_addr;
`ifdef LOOP_PLAYBACK_EN
        start_r <= start_addr;
`endif
      end
    end
  end

  // Sample side: every request is answered next cycle; an empty FIFO gives
  // silence, and counts as an underrun only while a clip is active.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      if (sample_req) begin
        sample_data <= (fifo_count != '0) ? fifo_head : DATA_W'(SILENCE);
      end
      if (start_ok) begin
        underrun <= 1'b0;
      end else if (sample_req && (fifo_count == '0) && playing) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_fetch_sched.sv
// tb_sample_fetch_sched: self-checking bench for sample_fetch_sched.
// A bridge slave with random ack latency serves data derived from the
// address; a queue-based model of the clip predicts read addresses, FIFO
// contents, sample answers, underrun, playing and done.
module tb_sample_fetch_sched;

  localparam int DEPTH = 8;
  localparam int LOW_WATER = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [25:0] start_addr = '0;
  logic [25:0] end_addr = '0;
  logic [25:0] bridge_address;
  logic        bridge_read;
  logic [1:0]  bridge_byte_enable;
  logic        bridge_acknowledge = 1'b0;
  logic [15:0] bridge_read_data = '0;
  logic        sample_req = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        playing;
  logic        underrun;
  logic        done;

  sample_fetch_sched dut (
    .Clk                (Clk),
    .Reset_n            (Reset_n),
    .start              (start),
    .stop               (stop),
    .start_addr         (start_addr),
    .end_addr           (end_addr),
    .bridge_address     (bridge_address),
    .bridge_read        (bridge_read),
    .bridge_byte_enable (bridge_byte_enable),
    .bridge_acknowledge (bridge_acknowledge),
    .bridge_read_data   (bridge_read_data),
    .sample_req         (sample_req),
    .sample_data        (sample_data),
    .sample_valid       (sample_valid),
    .playing            (playing),
    .underrun           (underrun),
    .done               (done)
  );

  always #10 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model
  logic [15:0] q[$];
  bit          active, aborting, refill, reads_done, underrun_m;
  bit          exp_valid, exp_done;
  logic [15:0] exp_sdata;
  logic [25:0] exp_addr, start_a, end_a;
  logic [25:0] sa_i, ea_i;
  // bridge slave
  bit          busy;
  int          lat_cnt, lat_min, lat_span;

  function automatic logic [15:0] pcm_of(input logic [25:0] a);
    return {a[7:0] ^ 8'h5A, ~a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    sample_req = 1'b0;
    bridge_acknowledge = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_read", bridge_read, 1'b0);
    chk("rst_addr", bridge_address, 26'h0);
    chk("rst_byte_en", bridge_byte_enable, 2'b11);
    chk("rst_sdata", sample_data, 16'h0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_playing", playing, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_done", done, 1'b0);
    Reset_n = 1'b1;
    q.delete();
    active = 0; aborting = 0; refill = 0; reads_done = 1; underrun_m = 0;
    exp_valid = 0; exp_done = 0; busy = 0; lat_cnt = 0;
  endtask

  // One clock cycle: check the outputs against the model, answer the bridge,
  // drive the inputs and advance the model across the coming edge.
  task automatic tick(input bit req_i, input bit start_i, input bit stop_i);
    bit rd_exp, ack;
    int qs;
    chk("sample_valid", sample_valid, exp_valid);
    if (exp_valid) chk("sample_data", sample_data, exp_sdata);
    chk("done", done, exp_done);
    chk("playing", playing, active);
    chk("underrun", underrun, underrun_m);
    rd_exp = active && (aborting || (refill && !reads_done));
    chk("bridge_read", bridge_read, rd_exp);
    if (rd_exp) chk("bridge_address", bridge_address, exp_addr);

    ack = 0;
    if (bridge_read) begin
      if (!busy) begin
        busy = 1;
        lat_cnt = lat_min + int'($urandom_range(lat_span));
      end
      if (lat_cnt == 0) begin
        ack = 1;
        busy = 0;
      end else begin
        lat_cnt--;
      end
    end
    bridge_acknowledge = ack;
    bridge_read_data   = ack ? pcm_of(bridge_address) : 16'($urandom);
    sample_req = req_i;
    start = start_i;
    stop = stop_i;
    start_addr = sa_i;
    end_addr = ea_i;

    qs = q.size();
    exp_done = 0;
    exp_valid = req_i;
    if (req_i) begin
      if (qs != 0) exp_sdata = q.pop_front();
      else begin
        exp_sdata = 16'h0;
        if (active) underrun_m = 1;
      end
    end
    if (active) begin
      if (aborting) begin
        if (ack) begin q.delete(); active = 0; aborting = 0; exp_done = 1; end
      end else if (stop_i) begin
        if (rd_exp && !ack) aborting = 1;
        else begin q.delete(); active = 0; exp_done = 1; end
      end else if (reads_done && qs == 0) begin
        active = 0;
        exp_done = 1;
      end else begin
        if (!refill && qs <= LOW_WATER) refill = 1;
        if (ack && rd_exp) begin
          q.push_back(pcm_of(exp_addr));
          if (exp_addr == end_a) begin
`ifdef LOOP_PLAYBACK_EN
            exp_addr = start_a;
`else
            reads_done = 1;
`endif
          end else begin
            exp_addr = exp_addr + 26'd1;
          end
          if (q.size() == DEPTH && !reads_done) refill = 0;
        end
      end
    end else if (start_i && !stop_i) begin
      if (sa_i <= ea_i) begin
        active = 1; refill = 1; reads_done = 0; aborting = 0; underrun_m = 0;
        exp_addr = sa_i; start_a = sa_i; end_a = ea_i;
        q.delete();
      end else begin
        exp_done = 1;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic run_until_idle(input int maxc, input int pct);
    int n = 0;
    while ((active || exp_done) && n < maxc) begin
      tick($urandom_range(99) < pct, 1'b0, 1'b0);
      n++;
    end
    chk("idle_reached", playing, 1'b0);
  endtask

  initial begin
    int len, pct, stop_at, n;
    lat_min = 0;
    lat_span = 0;
    sa_i = '0;
    ea_i = '0;
    do_reset();

    // four-word clip, fixed latency 2, drain with four requests
    lat_min = 2; lat_span = 0;
    sa_i = 26'h100; ea_i = 26'h103;
    tick(0, 1, 0);
    repeat (14) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
    run_until_idle(20, 0);

    // 20-word clip: fill, stall, refill after four pops
    lat_min = 0; lat_span = 1;
    sa_i = 26'h2000; ea_i = 26'h2013;
    tick(0, 1, 0);
    repeat (30) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    repeat (6) tick(0, 0, 0);
    run_until_idle(400, 40);

    // stop while waiting for space
    sa_i = 26'h500; ea_i = 26'h520;
    tick(0, 1, 0);
    repeat (25) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(1, 0, 0);
    tick(0, 0, 0);

    // underrun in FETCH, sticky, then reset mid-FETCH
    lat_min = 3; lat_span = 0;
    sa_i = 26'h40; ea_i = 26'h4F;
    tick(0, 1, 0);
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
    do_reset();

    // reversed range is rejected; start with stop is ignored
    sa_i = 26'h10; ea_i = 26'h0F;
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    sa_i = 26'h10; ea_i = 26'h20;
    tick(0, 1, 1);
    repeat (3) tick(0, 0, 0);

    // stop with a slow ack pending: request held, data discarded, FIFO empty
    lat_min = 5; lat_span = 0;
    sa_i = 26'h300; ea_i = 26'h30F;
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    run_until_idle(30, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);

`ifdef LOOP_PLAYBACK_EN
    lat_min = 0; lat_span = 2;
    sa_i = 26'h20; ea_i = 26'h21;
    tick(0, 1, 0);
    repeat (80) tick($urandom_range(99) < 50, 0, 0);
    tick(0, 0, 1);
    run_until_idle(30, 0);
`endif

    // randomized clips, latencies, request rates and stops
    for (int it = 0; it < 25; it++) begin
      sa_i = 26'($urandom_range(4000, 1));
      len = int'($urandom_range(24));
      if (it % 6 == 5) ea_i = sa_i - 26'd1;
      else ea_i = sa_i + 26'(len);
      lat_min = int'($urandom_range(2));
      lat_span = int'($urandom_range(3));
      pct = int'($urandom_range(90, 20));
      stop_at = ($urandom_range(3) == 0) ? int'($urandom_range(60, 3)) : -1;
      tick(0, 1, 0);
      n = 0;
      while ((active || exp_done) && n < 600) begin
        tick($urandom_range(99) < pct, 1'b0, n == stop_at);
        n++;
      end
      chk("rand_idle", playing, 1'b0);
      tick(0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
